// File: rtl/toggle_pulse_decoder.sv
// toggle_pulse_decoder: recovers one event per level change of an asynchronous toggle signal
// Ports:
//   i_clk      rising-edge clock
//   i_rst_n    asynchronous active-low reset
//   i_data     toggle level from the remote T flip-flop, asynchronous to i_clk
//   i_ready    consumer takes one queued event when o_valid && i_ready
//   i_clr_ovf  clears the sticky overflow flag
//   o_pulse    one-cycle strobe per detected toggle
//   o_valid    at least one event is queued
//   o_pending  number of queued, unconsumed events (saturates at 2**PEND_W-1)
//   o_overflow sticky: a toggle was dropped because the queue was full
//   o_count    total toggles detected, wrapping (only with TOGGLE_COUNT_EN)
// Optional feature: define TOGGLE_COUNT_EN to add the o_count port and its counter.
module toggle_pulse_decoder #(
   parameter int SYNC_STAGES = 2,
   parameter int PEND_W      = 3,
   parameter int CNT_W       = 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_data,
   input  logic              i_ready,
   input  logic              i_clr_ovf,
   output logic              o_pulse,
   output logic              o_valid,
   output logic [PEND_W-1:0] o_pending,
   output logic              o_overflow
`ifdef TOGGLE_COUNT_EN
   ,
   output logic [CNT_W-1:0]  o_count
`endif
);
   localparam logic [0:0]        PRIME    = 1'b0;
   localparam logic [0:0]        RUN      = 1'b1;
   localparam logic [PEND_W-1:0] PEND_ONE = 1;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic [0:0]             r_state;
   logic [2:0]             r_prime_cnt;
   logic                   r_pulse;
   logic [PEND_W-1:0]      r_pending;
   logic                   r_overflow;
   logic                   w_s;
   logic                   w_edge;
   logic                   w_drain;
   logic                   w_full;
   logic                   w_drop;
   assign w_s        = r_sync[SYNC_STAGES-1];
   assign w_edge     = (r_state == RUN) && (w_s != r_prev);
   assign o_valid    = |r_pending;
   assign w_drain    = o_valid && i_ready;
   assign w_full     = &r_pending;
   assign w_drop     = w_edge && !w_drain && w_full;
   assign o_pulse    = r_pulse;
   assign o_pending  = r_pending;
   assign o_overflow = r_overflow;
   // PRIME lasts SYNC_STAGES+1 cycles so a level already high at reset release
   // flushes through the chain without being mistaken for a toggle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync      <= '0;
         r_prev      <= 1'b0;
         r_state     <= PRIME;
         r_prime_cnt <= 3'd0;
         r_pulse     <= 1'b0;
         r_pending   <= '0;
         r_overflow  <= 1'b0;
      end else begin
         r_sync  <= {r_sync[SYNC_STAGES-2:0], i_data};
         r_prev  <= w_s;
         r_pulse <= w_edge;
         if (r_state == PRIME) begin
            r_prime_cnt <= r_prime_cnt + 3'd1;
            if (r_prime_cnt == 3'(SYNC_STAGES)) r_state <= RUN;
         end
         // An edge and a drain in the same cycle cancel out; a full queue drops the edge.
         if (w_edge && !w_drain && !w_full) r_pending <= r_pending + PEND_ONE;
         else if (!w_edge && w_drain) r_pending <= r_pending - PEND_ONE;
         // Setting takes priority over clearing.
         r_overflow <= w_drop || (r_overflow && !i_clr_ovf);
      end
   end
`ifdef TOGGLE_COUNT_EN
   localparam logic [CNT_W-1:0] CNT_ONE = 1;
   logic [CNT_W-1:0] r_count;
   assign o_count = r_count;
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_count <= '0;
      else if (w_edge) r_count <= r_count + CNT_ONE;
   end
`endif
endmodule

// File: tb/tb_toggle_pulse_decoder.sv
// tb_toggle_pulse_decoder: self-checking bench for toggle_pulse_decoder
module tb_toggle_pulse_decoder;
   localparam int S    = 2;
   localparam int PW   = 3;
   localparam int CW   = 8;
   localparam int MAXP = (1 << PW) - 1;
   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          data = 1'b1;
   logic          ready = 1'b0;
   logic          clr_ovf = 1'b0;
   logic          pulse;
   logic          valid;
   logic [PW-1:0] pending;
   logic          ovf;
`ifdef TOGGLE_COUNT_EN
   logic [CW-1:0] cnt;
`endif
   int n_cmp = 0;
   int n_bad = 0;
   int n_pulse = 0;
   toggle_pulse_decoder #(.SYNC_STAGES(S), .PEND_W(PW), .CNT_W(CW)) dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .i_data(data),
      .i_ready(ready),
      .i_clr_ovf(clr_ovf),
      .o_pulse(pulse),
      .o_valid(valid),
      .o_pending(pending),
      .o_overflow(ovf)
`ifdef TOGGLE_COUNT_EN
      ,
      .o_count(cnt)
`endif
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask
   // Model: an event is a change in the input sample stream seen S edges late,
   // ignored for the first S+1 edges after reset; the queue is a saturating counter.
   int  k = 0;
   bit  samp[$];
   int  m_pend = 0;
   bit  m_pulse = 0;
   bit  m_ovf = 0;
   int  m_cnt = 0;
   bit  ev;
   bit  dr;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k = 0;
         samp.delete();
         m_pend = 0;
         m_pulse = 0;
         m_ovf = 0;
         m_cnt = 0;
      end else begin
         k++;
         samp.push_back(data);
         ev = (k >= S + 2) && (samp[k-S-1] != samp[k-S-2]);
         dr = (m_pend > 0) && ready;
         m_ovf = (ev && !dr && m_pend == MAXP) || (m_ovf && !clr_ovf);
         if (ev && !dr && m_pend < MAXP) m_pend++;
         else if (!ev && dr) m_pend--;
         if (ev) m_cnt = (m_cnt + 1) % (1 << CW);
         m_pulse = ev;
      end
   end
   always @(negedge clk) begin
      if (pulse) n_pulse++;
      chk("pulse", int'(pulse), int'(m_pulse));
      chk("valid", int'(valid), int'(m_pend != 0));
      chk("pending", int'(pending), m_pend);
      chk("overflow", int'(ovf), int'(m_ovf));
`ifdef TOGGLE_COUNT_EN
      chk("count", int'(cnt), m_cnt);
`endif
   end
   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #2;
   endtask
   task automatic tog();
      data = ~data;
   endtask
   initial begin
      // 1: data high through reset, no spurious event after release
      step(3);
      chk("rst_pending", int'(pending), 0);
      chk("rst_pulse", int'(pulse), 0);
      chk("rst_overflow", int'(ovf), 0);
      rst_n = 1'b1;
      step(6);
      chk("t1_pulses", n_pulse, 0);
      chk("t1_pending", int'(pending), 0);
      chk("t1_valid", int'(valid), 0);
      // 2: single toggle, pulse after S+1 edges, then drain
      tog();
      step(1);
      chk("t2_pulse_e1", int'(pulse), 0);
      step(1);
      chk("t2_pulse_e2", int'(pulse), 0);
      step(1);
      chk("t2_pulse_e3", int'(pulse), 1);
      chk("t2_pending", int'(pending), 1);
      chk("t2_valid", int'(valid), 1);
      step(1);
      chk("t2_pulse_e4", int'(pulse), 0);
      ready = 1'b1;
      step(1);
      ready = 1'b0;
      chk("t2_drained", int'(pending), 0);
      chk("t2_valid_low", int'(valid), 0);
      // 3: eight toggles with no consumer
      n_pulse = 0;
      for (int i = 0; i < 8; i++) begin
         tog();
         step(5);
      end
      chk("t3_pulses", n_pulse, 8);
      chk("t3_pending", int'(pending), 7);
      chk("t3_overflow", int'(ovf), 1);
`ifdef TOGGLE_COUNT_EN
      chk("t3_count", int'(cnt), 9);
`endif
      // 4: edge coincides with a drain while full
      clr_ovf = 1'b1;
      step(1);
      clr_ovf = 1'b0;
      chk("t4_cleared", int'(ovf), 0);
      tog();
      step(2);
      ready = 1'b1;
      step(1);
      ready = 1'b0;
      chk("t4_pulse", int'(pulse), 1);
      chk("t4_pending", int'(pending), 7);
      chk("t4_overflow", int'(ovf), 0);
      // 5: overflow set and clear in the same cycle
      tog();
      step(2);
      clr_ovf = 1'b1;
      step(1);
      clr_ovf = 1'b0;
      chk("t5_set_wins", int'(ovf), 1);
      clr_ovf = 1'b1;
      step(1);
      clr_ovf = 1'b0;
      chk("t5_clear", int'(ovf), 0);
      // 6: reset mid-stream with 5 queued
      ready = 1'b1;
      step(2);
      ready = 1'b0;
      chk("t6_pending5", int'(pending), 5);
      rst_n = 1'b0;
      data = 1'b1;
      #1;
      chk("t6_async_pending", int'(pending), 0);
      chk("t6_async_valid", int'(valid), 0);
      chk("t6_async_pulse", int'(pulse), 0);
      step(1);
      rst_n = 1'b1;
      n_pulse = 0;
      step(6);
      chk("t6_prime_pulses", n_pulse, 0);
      chk("t6_prime_pending", int'(pending), 0);
      tog();
      step(4);
      chk("t6_pending1", int'(pending), 1);
      chk("t6_pulses", n_pulse, 1);
      // 7: 256 toggles with a ready consumer, counter wraps back to its start
      ready = 1'b1;
      for (int i = 0; i < 256; i++) begin
         tog();
         step(3);
      end
      step(4);
      ready = 1'b0;
      chk("t7_pending", int'(pending), 0);
      chk("t7_overflow", int'(ovf), 0);
`ifdef TOGGLE_COUNT_EN
      chk("t7_count_wrap", int'(cnt), 1);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
